// File: rtl/expipe_pkg.sv
// Shared execution-pipe types: CDB payload bundle and station slot numbers.
// Widths here are fixed for the whole backend, not per-instance parameters.
package expipe_pkg;

    localparam int XLEN           = 64;
    localparam int ROB_IDX_LEN    = 5;
    localparam int ROB_EXCEPT_LEN = 4;

    localparam int EU_LSU    = 0;
    localparam int EU_ALU    = 1;
    localparam int EU_BRANCH = 2;
    localparam int EU_MULT   = 3;
    localparam int EU_DIV    = 4;
    localparam int EU_NUM    = 5;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0]    rob_idx;
        logic [XLEN-1:0]           res_value;
        logic                      except_raised;
        logic [ROB_EXCEPT_LEN-1:0] except_code;
    } cdb_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way priority picker starting its scan at ptr_i.
// Produces a one-hot grant, the binary winner index and an any-grant flag.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) pos = pos - N;
            if (!valid_o && req_i[pos]) begin
                grant_o[pos] = 1'b1;
                idx_o        = IW'(pos);
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished station per cycle into a CDB slot.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cdb_arbiter
    import expipe_pkg::*;
#(
    parameter  int N_EU = 5,
    localparam int IW   = (N_EU > 1) ? $clog2(N_EU) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 flush_i,
    input  logic [N_EU-1:0]                      rs_valid_i,
    output logic [N_EU-1:0]                      rs_ready_o,
    input  logic [N_EU-1:0][ROB_IDX_LEN-1:0]     rs_idx_i,
    input  logic [N_EU-1:0][XLEN-1:0]            rs_data_i,
    input  logic [N_EU-1:0]                      rs_except_raised_i,
    input  logic [N_EU-1:0][ROB_EXCEPT_LEN-1:0]  rs_except_i,
    input  logic                                 rob_ready_i,
    output logic                                 cdb_valid_o,
    output logic [ROB_IDX_LEN-1:0]               cdb_idx_o,
    output logic [XLEN-1:0]                      cdb_data_o,
    output logic                                 cdb_except_raised_o,
    output logic [ROB_EXCEPT_LEN-1:0]            cdb_except_o
);

    logic            can_load;
    logic [N_EU-1:0] req;
    logic [N_EU-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            xfer;
    logic [IW-1:0]   rr_ptr;
    cdb_data_t       sel;
    cdb_data_t       cdb_q;

    assign can_load = !cdb_valid_o || rob_ready_i;
    // No grant may leak out while reset or flush is active.
    assign req = (can_load && !flush_i && rst_n_i) ? rs_valid_i : '0;

    rr_arbiter #(.N(N_EU)) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr),
        .grant_o (grant),
        .idx_o   (gidx),
        .valid_o (xfer)
    );

    assign rs_ready_o = grant;

    always_comb begin
        sel               = '0;
        sel.rob_idx       = rs_idx_i[gidx];
        sel.res_value     = rs_data_i[gidx];
        sel.except_raised = rs_except_raised_i[gidx];
        sel.except_code   = rs_except_i[gidx];
    end

`ifdef CDB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gidx == IW'(N_EU - 1)) ? '0 : gidx + IW'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cdb_valid_o <= 1'b0;
            cdb_q       <= '0;
        end else if (flush_i) begin
            cdb_valid_o <= 1'b0;
        end else if (xfer) begin
            cdb_valid_o <= 1'b1;
            cdb_q       <= sel;
        end else if (rob_ready_i) begin
            cdb_valid_o <= 1'b0;
        end
    end

    assign cdb_idx_o           = cdb_q.rob_idx;
    assign cdb_data_o          = cdb_q.res_value;
    assign cdb_except_raised_o = cdb_q.except_raised;
    assign cdb_except_o        = cdb_q.except_code;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (round-robin or CDB_FIXED_PRIO_EN build).
module tb_cdb_arbiter;
    import expipe_pkg::*;

    localparam int N = 5;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic                                flush;
    logic [N-1:0]                        rs_valid;
    logic [N-1:0]                        rs_ready;
    logic [N-1:0][ROB_IDX_LEN-1:0]       rs_idx;
    logic [N-1:0][XLEN-1:0]              rs_data;
    logic [N-1:0]                        rs_exr;
    logic [N-1:0][ROB_EXCEPT_LEN-1:0]    rs_exc;
    logic                                rob_ready;
    logic                                cdb_valid;
    logic [ROB_IDX_LEN-1:0]              cdb_idx;
    logic [XLEN-1:0]                     cdb_data;
    logic                                cdb_exr;
    logic [ROB_EXCEPT_LEN-1:0]           cdb_exc;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [N-1:0] v;
        logic         rr;
        logic         fl;
        logic [N-1:0] rdy;
        logic         ev;
        int           st;
    } vec_t;

    vec_t tbl[$];

    cdb_arbiter #(.N_EU(N)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .flush_i             (flush),
        .rs_valid_i          (rs_valid),
        .rs_ready_o          (rs_ready),
        .rs_idx_i            (rs_idx),
        .rs_data_i           (rs_data),
        .rs_except_raised_i  (rs_exr),
        .rs_except_i         (rs_exc),
        .rob_ready_i         (rob_ready),
        .cdb_valid_o         (cdb_valid),
        .cdb_idx_o           (cdb_idx),
        .cdb_data_o          (cdb_data),
        .cdb_except_raised_o (cdb_exr),
        .cdb_except_o        (cdb_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [ROB_IDX_LEN-1:0] idx_of(input int st);
        case (st)
            0: idx_of = 5'd2;
            1: idx_of = 5'd3;
            2: idx_of = 5'd4;
            3: idx_of = 5'd5;
            default: idx_of = 5'd7;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < N; k++) begin
            rs_idx[k] = idx_of(k);
            rs_data[k] = 64'(k ^ 7);
            rs_exr[k] = (k == EU_DIV);
            rs_exc[k] = ROB_EXCEPT_LEN'(k + 1);
        end
`ifdef CDB_FIXED_PRIO_EN
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b10000, 1'b1, 1'b0, 5'b10000, 1'b1, 4});
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b10001, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b10000, 1'b1, 1'b0, 5'b10000, 1'b1, 4});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 4});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 4});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 4});
        tbl.push_back('{5'b01010, 1'b1, 1'b0, 5'b00010, 1'b1, 1});
        tbl.push_back('{5'b01000, 1'b1, 1'b0, 5'b01000, 1'b1, 3});
        tbl.push_back('{5'b00101, 1'b1, 1'b1, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b00101, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00101, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b00001, 1'b0, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00001, 1'b0, 1'b0, 5'b00000, 1'b1, 0});
`else
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b10000, 1'b1, 1'b0, 5'b10000, 1'b1, 4});
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1, 1});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00100, 1'b1, 2});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b01000, 1'b1, 3});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1, 4});
        tbl.push_back('{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 0});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 0});
        tbl.push_back('{5'b01010, 1'b0, 1'b0, 5'b00000, 1'b1, 0});
        tbl.push_back('{5'b01010, 1'b1, 1'b0, 5'b00010, 1'b1, 1});
        tbl.push_back('{5'b01000, 1'b1, 1'b0, 5'b01000, 1'b1, 3});
        tbl.push_back('{5'b00101, 1'b1, 1'b1, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b00101, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00101, 1'b1, 1'b0, 5'b00100, 1'b1, 2});
        tbl.push_back('{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 2});
        tbl.push_back('{5'b00011, 1'b1, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00011, 1'b1, 1'b0, 5'b00010, 1'b1, 1});
        tbl.push_back('{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 0});
        tbl.push_back('{5'b00001, 1'b0, 1'b0, 5'b00001, 1'b1, 0});
        tbl.push_back('{5'b00001, 1'b0, 1'b0, 5'b00000, 1'b1, 0});
`endif

        rst_n = 1'b0;
        flush = 1'b0;
        rob_ready = 1'b1;
        rs_valid = '1;
        #12;
        check("reset_ready", 64'(rs_ready), 64'd0);
        check("reset_valid", 64'(cdb_valid), 64'd0);
        check("reset_idx", 64'(cdb_idx), 64'd0);
        check("reset_data", cdb_data, 64'd0);
        rs_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rs_valid = tbl[i].v;
            rob_ready = tbl[i].rr;
            flush = tbl[i].fl;
            #1;
            check($sformatf("v%0d_ready", i), 64'(rs_ready), 64'(tbl[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 64'(cdb_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("v%0d_idx", i), 64'(cdb_idx),
                      64'(idx_of(tbl[i].st)));
                check($sformatf("v%0d_data", i), cdb_data, 64'(tbl[i].st ^ 7));
                check($sformatf("v%0d_exr", i), 64'(cdb_exr),
                      64'(tbl[i].st == EU_DIV));
                check($sformatf("v%0d_exc", i), 64'(cdb_exc),
                      64'(tbl[i].st + 1));
            end
        end

        // Async reset mid-cycle while the CDB slot is full.
        rs_valid = '0;
        rob_ready = 1'b0;
        flush = 1'b0;
        #2;
        check("pre_rst_valid", 64'(cdb_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(cdb_valid), 64'd0);
        check("async_rst_idx", 64'(cdb_idx), 64'd0);
        rs_valid = 5'b00100;
        #1;
        check("async_rst_ready", 64'(rs_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rob_ready = 1'b1;
        rs_valid = 5'b10100;
        #1;
        check("post_rst_ready", 64'(rs_ready), 64'b00100);
        @(posedge clk);
        #1;
        check("post_rst_idx", 64'(cdb_idx), 64'(idx_of(2)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the reservation stations (ALU, MULT, DIV, branch, load/store).
- Collects each station's completed-result handshake and grants one station per cycle.
- Registers the winner into a single output slot and broadcasts it on the common data bus (CDB) to the ROB and all reservation stations.
- Round-robin arbitration, one-cycle latency, full throughput of one result per cycle.

Parameters:
- N_EU, 5, number of reservation stations competing for the CDB (≥2).
- Widths come from the shared package and are not parameters: XLEN, ROB_IDX_LEN, ROB_EXCEPT_LEN.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush; synchronous clear
- rs_valid_i  in  N_EU  station k has a result (its cdb_valid_o)
- rs_ready_o  out  N_EU  grant to station k (drives its cdb_ready_i)
- rs_idx_i  in  N_EU×ROB_IDX_LEN  per-station ROB index
- rs_data_i  in  N_EU×XLEN  per-station result
- rs_except_raised_i  in  N_EU  per-station exception flag
- rs_except_i  in  N_EU×ROB_EXCEPT_LEN  per-station exception code
- rob_ready_i  in  1  ROB can accept the CDB result this cycle
- cdb_valid_o  out  1  CDB carries valid data
- cdb_idx_o  out  ROB_IDX_LEN  broadcast ROB index
- cdb_data_o  out  XLEN  broadcast result
- cdb_except_raised_o  out  1  broadcast exception flag
- cdb_except_o  out  ROB_EXCEPT_LEN  broadcast exception code

Behaviour:
- Reset (async, rst_n_i=0):
  - cdb_valid_o=0; cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o all 0.
  - rr_ptr=0.
- rs_ready_o is combinational. It is all-zero when reset or flush_i is asserted.
- Output slot free: can_load = !cdb_valid_o || rob_ready_i.
- Grant:
  - If can_load, grant exactly the first k with rs_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, … modulo N_EU.
  - rs_ready_o is one-hot on that k, otherwise all zero.
  - rs_ready_o never depends on rs_valid_i of the same station beyond selection; it is not asserted to a non-requesting station.
- Transfer when rs_valid_i[k] && rs_ready_o[k]:
  - Next edge: output registers load station k's idx/data/except fields; cdb_valid_o=1.
  - rr_ptr = (k+1) mod N_EU, wrapping from N_EU-1 to 0.
- No transfer and rob_ready_i=1: next edge cdb_valid_o=0. Data registers hold their value; don't-care.
- cdb_valid_o=1 and rob_ready_i=0: output registers hold, all rs_ready_o=0 (back-pressure). rr_ptr holds.
- Simultaneous consume and load (rob_ready_i=1, new grant): the new result replaces the old one in the same edge, giving no bubble.
- rr_ptr changes only on a transfer. With no requests it holds.
- Latency: a station's valid → cdb_valid_o is 1 cycle when it wins.
- Starvation bound: a continuously requesting station wins within N_EU granted cycles.
- flush_i (sync, priority over everything):
  - Next edge: cdb_valid_o=0, rr_ptr=0.
  - rs_ready_o=0 in the flush cycle, so no result is consumed from any station.
- Reset mid-transfer: the output is dropped immediately (async). Stations retain their entries; they are flushed by their own reset.

Optional Feature:
- CDB_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority; the lowest index wins.
  - The rr_ptr register is not instantiated.
  - Intended for the load/store unit at index 0.
- Not defined: round-robin as above.
- All handshake and latency rules are otherwise identical.

Decomposition:
- expipe_pkg:
  - Add cdb_data_t packed struct {rob_idx, res_value, except_raised, except_code} using ROB_IDX_LEN, XLEN, ROB_EXCEPT_LEN.
  - Add EU index constants naming each station's slot (EU_LSU=0, EU_ALU, EU_BRANCH, EU_MULT, EU_DIV).
- One sub-module: rr_arbiter.
  - Combinational N_EU-wide priority picker given a start pointer.
  - Outputs a one-hot grant and a binary index.
  - Reused by the issue-side arbiter later.

Test Plan:
- Reset then idle: rs_valid_i=0 → cdb_valid_o=0, rs_ready_o=0; assert rst_n_i=0 mid-run with cdb_valid_o=1 → cdb_valid_o=0 immediately.
- Single DIV request: station 4, idx=7, data=0x0000_0000_0000_0003, rob_ready_i=1 → rs_ready_o=5'b10000 same cycle; next cycle cdb_valid_o=1, cdb_idx_o=7, cdb_data_o=3; rr_ptr=0.
- All five stations request continuously, rob_ready_i=1 → grants 0,1,2,3,4,0 on consecutive cycles; cdb_valid_o stays 1; no bubbles.
- Back-pressure: cdb_valid_o=1 (idx=2), rob_ready_i=0 for 3 cycles with stations 1,3 requesting → rs_ready_o=0 and cdb_idx_o=2 held; on release, station 1 granted, then station 3.
- Flush: stations 0,2 requesting and cdb_valid_o=1, flush_i=1 → rs_ready_o=0 that cycle; next cycle cdb_valid_o=0, and station 0 wins first afterwards.
- With CDB_FIXED_PRIO_EN: stations 0 and 4 requesting constantly → station 0 wins every cycle; station 4 never granted until station 0 drops.
